bcd_scan_counter: RTL and testbench

Parametrised multi-digit BCD up/down counter with a built-in time-multiplexed 7-segment driver for common-anode displays. It generalises the single-digit load/count/decode block to DIGITS cascaded decades, adds direction control, count enable, a wrap pulse and leading-zero blanking, and drives a shared segment bus plus per-digit anode selects. It sits between the board I/O and the display header.

---
 rtl/bcd_scan_counter.sv | 158 +++++++++++++++
 tb/tb_bcd_scan_counter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter
//   DIGITS cascaded BCD decades counting up or down, with a time-multiplexed
//   common-anode 7-segment driver on a shared segment bus.
//
//   Ports:
//     clk      system clock, rising edge
//     rst_syn  asynchronous active-low reset
//     en       count enable
//     up_dn    1 = up, 0 = down
//     load_syn synchronous parallel load (wins over en)
//     Din      load value, digit 0 in [3:0]; digits > 9 load as 0
//     Q_out    current BCD count
//     carry    one-cycle pulse after the edge on which the whole chain wraps
//     seg      active-low segments {dp,g,f,e,d,c,b,a}, dp always off
//     an       active-low one-hot digit select

// One decade: holds a BCD digit and steps it when the ripple chain reaches it.
module bcd_digit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] din,
  input  logic       step,
  input  logic       up_dn,
  output logic [3:0] q,
  output logic       term
);
  // term: this digit is at its wrap point, so a step here ripples onward
  assign term = up_dn ? (q == 4'd9) : (q == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q <= 4'd0;
    else if (load) q <= (din > 4'd9) ? 4'd0 : din;
    else if (step) begin
      if (up_dn) q <= (q == 4'd9) ? 4'd0 : q + 4'd1;
      else       q <= (q == 4'd0) ? 4'd9 : q - 4'd1;
    end
  end
endmodule

module bcd_scan_counter #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_syn,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  load_syn,
  input  logic [4*DIGITS-1:0]   Din,
  output logic [4*DIGITS-1:0]   Q_out,
  output logic                  carry,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(SCAN_DIV);

  logic [DIGITS-1:0][3:0] q;
  logic [DIGITS-1:0][3:0] din_v;
  logic [DIGITS-1:0]      term;
  logic [DIGITS:0]        chain;   // chain[i]: digit i steps this edge
  logic [DIGITS:0]        zhi;     // zhi[i]: digits i..DIGITS-1 all zero
  logic [DIGITS-1:0]      blank;

  assign din_v    = Din;
  assign Q_out    = q;
  assign chain[0] = en;
  assign zhi[DIGITS] = 1'b1;

  genvar i;
  generate
    for (i = 0; i < DIGITS; i++) begin : g_dig
      bcd_digit u_dig (
        .clk   (clk),
        .rst_n (rst_syn),
        .load  (load_syn),
        .din   (din_v[i]),
        .step  (chain[i]),
        .up_dn (up_dn),
        .q     (q[i]),
        .term  (term[i])
      );
      assign chain[i+1] = chain[i] & term[i];
      assign zhi[i]     = zhi[i+1] & (q[i] == 4'd0);
      if (i == 0) begin : g_d0
        assign blank[i] = 1'b0;
      end else begin : g_dn
        assign blank[i] = LZ_BLANK & zhi[i];
      end
    end
  endgenerate

  // Chain wrap = every digit was at its terminal value and en reached past the top.
  always_ff @(posedge clk or negedge rst_syn) begin
    if (!rst_syn) carry <= 1'b0;
    else          carry <= ~load_syn & chain[DIGITS];
  end

  function automatic logic [7:0] seg_dec(input logic [3:0] d, input logic blk);
    logic [7:0] s;
    if (blk) s = 8'hFF;
    else begin
      case (d)
        4'd0: s = 8'hC0;
        4'd1: s = 8'hF9;
        4'd2: s = 8'hA4;
        4'd3: s = 8'hB0;
        4'd4: s = 8'h99;
        4'd5: s = 8'h92;
        4'd6: s = 8'h82;
        4'd7: s = 8'hF8;
        4'd8: s = 8'h80;
        4'd9: s = 8'h90;
        default: s = 8'hFF;
      endcase
    end
    return s;
  endfunction

  logic [PW-1:0] presc;
  logic [IW-1:0] idx;
  logic [3:0]    sel_d;
  logic          sel_b;

  // Mux the currently scanned digit by compare, avoiding an out-of-range index
  // when DIGITS is not a power of two.
  always_comb begin
    sel_d = 4'd0;
    sel_b = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) begin
        sel_d = q[k];
        sel_b = blank[k];
      end
    end
  end

  // seg and an load on the same edge from the same index, so they never skew.
  always_ff @(posedge clk or negedge rst_syn) begin
    if (!rst_syn) begin
      presc <= '0;
      idx   <= '0;
      seg   <= 8'hFF;
      an    <= '1;
    end else begin
      seg <= seg_dec(sel_d, sel_b);
      an  <= ~(DIGITS'(1) << idx);
      if (presc == PW'(SCAN_DIV - 1)) begin
        presc <= '0;
        idx   <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end
endmodule

// File: tb/tb_bcd_scan_counter.sv
module tb_bcd_scan_counter;
  logic        clk = 1'b0;
  logic        rst_syn, en, up_dn, load_syn;
  logic [15:0] Din;
  logic [3:0]  din_c;
  logic [15:0] q_a, q_b;
  logic [3:0]  q_c;
  logic        carry_a, carry_b, carry_c;
  logic [7:0]  seg_a, seg_b, seg_c;
  logic [3:0]  an_a, an_b;
  logic        an_c;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  bcd_scan_counter #(.DIGITS(4), .SCAN_DIV(4), .LZ_BLANK(1'b1)) u_a (
    .clk(clk), .rst_syn(rst_syn), .en(en), .up_dn(up_dn), .load_syn(load_syn),
    .Din(Din), .Q_out(q_a), .carry(carry_a), .seg(seg_a), .an(an_a));

  bcd_scan_counter #(.DIGITS(4), .SCAN_DIV(4), .LZ_BLANK(1'b0)) u_b (
    .clk(clk), .rst_syn(rst_syn), .en(en), .up_dn(up_dn), .load_syn(load_syn),
    .Din(Din), .Q_out(q_b), .carry(carry_b), .seg(seg_b), .an(an_b));

  bcd_scan_counter #(.DIGITS(1), .SCAN_DIV(4), .LZ_BLANK(1'b1)) u_c (
    .clk(clk), .rst_syn(rst_syn), .en(en), .up_dn(up_dn), .load_syn(load_syn),
    .Din(din_c), .Q_out(q_c), .carry(carry_c), .seg(seg_c), .an(an_c));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] an_tab  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [7:0] sega_tab[4] = '{8'h92, 8'hC0, 8'hB0, 8'hFF};
  logic [7:0] segb_tab[4] = '{8'h92, 8'hC0, 8'hB0, 8'hC0};

  initial begin
    rst_syn = 1'b0; en = 1'b0; up_dn = 1'b1; load_syn = 1'b0;
    Din = 16'h0; din_c = 4'h0;
    #12;
    chk("rst_q",     q_a, 16'h0000);
    chk("rst_carry", carry_a, 1'b0);
    chk("rst_seg",   seg_a, 8'hFF);
    chk("rst_an",    an_a, 4'hF);

    // release between edges with a load of 0305 pending for edge 1
    Din = 16'h0305; din_c = 4'h5; load_syn = 1'b1;
    rst_syn = 1'b1;
    step();
    chk("ld0305_q",  q_a, 16'h0305);
    chk("e1_an",     an_a, 4'hE);
    chk("e1_seg",    seg_a, 8'hC0);   // decoded from pre-load value 0
    chk("e1_c_an",   an_c, 1'b0);
    load_syn = 1'b0;

    // edges 2..17: each digit held 4 edges, frame wraps back to digit 0
    for (int n = 2; n <= 17; n++) begin
      step();
      chk($sformatf("scan_an_e%0d", n),  an_a,  an_tab[((n-1)/4)%4]);
      chk($sformatf("scan_sa_e%0d", n),  seg_a, sega_tab[((n-1)/4)%4]);
      chk($sformatf("scan_sb_e%0d", n),  seg_b, segb_tab[((n-1)/4)%4]);
    end
    chk("c_seg5", seg_c, 8'h92);

    // up count across full wrap
    Din = 16'h9998; load_syn = 1'b1; en = 1'b1; up_dn = 1'b1;
    step();
    chk("ld9998", q_a, 16'h9998);
    load_syn = 1'b0;
    step();
    chk("up_9999",   q_a, 16'h9999);
    chk("up_c0",     carry_a, 1'b0);
    step();
    chk("up_0000",   q_a, 16'h0000);
    chk("up_c1",     carry_a, 1'b1);
    step();
    chk("up_0001",   q_a, 16'h0001);
    chk("up_c2",     carry_a, 1'b0);
    en = 1'b0;
    step();
    chk("hold_q",    q_a, 16'h0001);
    chk("hold_c",    carry_a, 1'b0);

    // down count across full wrap
    Din = 16'h0000; load_syn = 1'b1; en = 1'b1; up_dn = 1'b0;
    step();
    chk("ld0000",    q_a, 16'h0000);
    chk("ld_c",      carry_a, 1'b0);
    load_syn = 1'b0;
    step();
    chk("dn_9999",   q_a, 16'h9999);
    chk("dn_c1",     carry_a, 1'b1);
    step();
    chk("dn_9998",   q_a, 16'h9998);
    chk("dn_c2",     carry_a, 1'b0);

    // invalid digits load as 0; load beats en
    Din = 16'h12A4; din_c = 4'hB; load_syn = 1'b1; en = 1'b1;
    step();
    chk("ld12A4",    q_a, 16'h1204);
    chk("ldB_c",     q_c, 4'h0);

    // single decade: carry every 10th edge, never merged
    Din = 16'h0; din_c = 4'h0; up_dn = 1'b1;
    step();
    load_syn = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      step();
      chk($sformatf("c1_carry_%0d", k), carry_c, (k % 10 == 0) ? 1'b1 : 1'b0);
    end
    chk("c1_q", q_c, 4'h0);

    // async reset mid-count, mid-scan, with carry high
    Din = 16'h1239; din_c = 4'h9; load_syn = 1'b1;
    step();
    load_syn = 1'b0;
    step();
    chk("pre_q",     q_a, 16'h1240);
    chk("pre_cc",    carry_c, 1'b1);
    #3;
    rst_syn = 1'b0;
    #1;
    chk("arst_q",    q_a, 16'h0000);
    chk("arst_seg",  seg_a, 8'hFF);
    chk("arst_an",   an_a, 4'hF);
    chk("arst_cc",   carry_c, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
